// File: rtl/alu_pkg.sv
// Shared op encodings and FSM states for the bit-serial ALU sequencer.
// Consumed by bit_serial_alu_ctrl; optional OVERFLOW_DETECT_EN lives in the top.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bit_serial_alu_ctrl_slice.sv
// OneBitALU: single ALU bit slice (AND/OR/ADD/LESS with optional b invert).
// Shared by the bit-serial sequencer, one bit per clock.
module OneBitALU (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       set,
  output logic       g,
  output logic       p
);

  logic bb;
  logic sum;

  assign bb   = op[2] ? ~b : b;
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (a & cin) | (bb & cin);
  assign set  = sum;
  assign g    = a & bb;
  assign p    = a | bb;

  always_comb begin
    result = 1'b0;
    unique case (op[1:0])
      2'b00:   result = a & bb;
      2'b01:   result = a | bb;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: WIDTH-bit op through one OneBitALU, LSB first.
// Define OVERFLOW_DETECT_EN to add the overflow port and overflow-corrected SLT.
module bit_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef OVERFLOW_DETECT_EN
  output logic             zero,
  output logic             overflow
`else
  output logic             zero
`endif
);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, sh_q, fin;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] idx;
  logic             carry, set_q, last;
  logic             s_res, s_cout, s_set, slt_bit;
  logic             g_unused, p_unused;

  OneBitALU u_slice (
    .a      (a_q[idx]),
    .b      (b_q[idx]),
    .cin    (carry),
    .less   (1'b0),
    .op     (op_q),
    .result (s_res),
    .cout   (s_cout),
    .set    (s_set),
    .g      (g_unused),
    .p      (p_unused)
  );

  assign last = (idx == CNT_W'(WIDTH-1));
  assign busy = (state != S_IDLE);

`ifdef OVERFLOW_DETECT_EN
  // signed compare stays correct when a-b overflows
  assign slt_bit = set_q ^ overflow;
`else
  assign slt_bit = set_q;
`endif

  assign fin = (op_q[1:0] == 2'b11) ?
               {{(WIDTH-1){1'b0}}, slt_bit} : sh_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      sh_q   <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      set_q  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      overflow <= 1'b0;
`endif
    end else begin
      done <= (state == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            carry <= op[2];
            idx   <= '0;
          end
        end
        S_RUN: begin
          sh_q[idx] <= s_res;
          carry     <= s_cout;
          if (last) begin
            set_q <= s_set;
            cout  <= op_q[1] & s_cout;
`ifdef OVERFLOW_DETECT_EN
            overflow <= op_q[1] & (carry ^ s_cout);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          result <= fin;
          zero   <= ~|fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed self-checking bench for bit_serial_alu_ctrl (WIDTH=32).
// Build with +define+OVERFLOW_DETECT_EN to cover the overflow variant.
module tb_bit_serial_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        busy, done, cout, zero;
  logic [31:0] result;
`ifdef OVERFLOW_DETECT_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  bit_serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
`ifdef OVERFLOW_DETECT_EN
    .zero     (zero),
    .overflow (overflow)
`else
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; caller is #1 after a rising edge. Returns with done seen.
  task automatic run_op(input logic [31:0] ta,
                        input logic [31:0] tb_v,
                        input logic [2:0]  top,
                        input int          glitch);
    int cyc;
    bit got;
    a = ta; b = tb_v; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      if (cyc == glitch) begin
        start = 1'b1; a = ~ta; b = ~tb_v; op = 3'b001;
      end else if (cyc == glitch + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    chk("latency", cyc, 32'd33);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_result", result,        32'd0);
    chk("rst_cout",   {31'b0, cout}, 32'd0);
    chk("rst_zero",   {31'b0, zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd5, 32'd3, 3'b010, -5);
    chk("add_res",  result,        32'd8);
    chk("add_cout", {31'b0, cout}, 32'd0);
    chk("add_zero", {31'b0, zero}, 32'd0);

    run_op(32'd3, 32'd5, 3'b110, -5);
    chk("sub_res",  result,        32'hFFFF_FFFE);
    chk("sub_cout", {31'b0, cout}, 32'd0);

    run_op(32'd7, 32'd7, 3'b110, -5);
    chk("sub_eq_res",  result,        32'd0);
    chk("sub_eq_zero", {31'b0, zero}, 32'd1);
    chk("sub_eq_cout", {31'b0, cout}, 32'd1);

    run_op(32'd3, 32'd5, 3'b111, -5);
    chk("slt_lt", result, 32'd1);
    run_op(32'd5, 32'd3, 3'b111, -5);
    chk("slt_gt", result, 32'd0);

    run_op(32'h7FFF_FFFF, 32'h8000_0000, 3'b111, -5);
`ifdef OVERFLOW_DETECT_EN
    chk("slt_ovf_res", result,            32'd0);
    chk("slt_ovf_flg", {31'b0, overflow}, 32'd1);
`else
    chk("slt_ovf_res", result, 32'd1);
`endif

    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 7);
    chk("and_res",  result,        32'hF000_F000);
    chk("and_cout", {31'b0, cout}, 32'd0);
`ifdef OVERFLOW_DETECT_EN
    chk("and_ovf", {31'b0, overflow}, 32'd0);
`endif
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 12);
    chk("or_res",  result,        32'hFFF0_FFF0);
    chk("or_cout", {31'b0, cout}, 32'd0);

    // abort an ADD while bit 10 is in flight
    a = 32'h1234_5678; b = 32'h1111_1111; op = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   {31'b0, busy}, 32'd0);
    chk("abort_result", result,        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 32'd0);

    run_op(32'd1, 32'd1, 3'b010, -5);
    chk("post_abort_add", result, 32'd2);

    @(posedge clk); #1;
    chk("done_pulse_one", {31'b0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
